// File: rtl/traffic_sensor_conditioner.sv
// traffic_sensor_conditioner: synchronise, debounce and gap-extend two vehicle detectors, counting arrivals per street.
module tsc_channel #(
    parameter int DEB_CYCLES = 4,
    parameter int GAP_CYCLES = 8,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             raw,
    input  logic             clr_cnt,
    output logic             occ,
    output logic [CNT_W-1:0] cnt
);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
    typedef enum logic [1:0] {IDLE, OCC, GAP} state_t;
    state_t           state_q, state_d;
    logic             s1_q, s2_q, deb_q, deb_d, flip, arrive;
    logic [DW-1:0]    ctr_q, ctr_d;
    logic [GW-1:0]    tmr_q, tmr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    always_comb begin
        flip   = (s2_q != deb_q) && (ctr_q == DEB_LAST);
        arrive = flip && s2_q;
        deb_d  = flip ? s2_q : deb_q;
        ctr_d  = (s2_q == deb_q || flip) ? '0 : ctr_q + 1'b1;
        cnt_d  = clr_cnt ? CNT_W'(arrive) : (arrive && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        case (state_q)
            IDLE: if (deb_q) state_d = OCC;
            OCC: if (!deb_q) begin
                state_d = GAP;
                tmr_d   = GAP_LAST;
            end
            GAP: if (deb_q) state_d = OCC;
                 else if (tmr_q == '0) state_d = IDLE;
                 else tmr_d = tmr_q - 1'b1;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            deb_q   <= 1'b0;
            ctr_q   <= '0;
            tmr_q   <= '0;
            cnt_q   <= '0;
            state_q <= IDLE;
        end else begin
            s1_q    <= raw;
            s2_q    <= s1_q;
            deb_q   <= deb_d;
            ctr_q   <= ctr_d;
            tmr_q   <= tmr_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end
    assign occ = state_q != IDLE;
    assign cnt = cnt_q;
endmodule

module traffic_sensor_conditioner #(
    parameter int DEB_CYCLES = 4,
    parameter int GAP_CYCLES = 8,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             raw_a,
    input  logic             raw_b,
    input  logic             clr_cnt,
    output logic             a,
    output logic             b,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);
    tsc_channel #(.DEB_CYCLES(DEB_CYCLES), .GAP_CYCLES(GAP_CYCLES), .CNT_W(CNT_W)) u_a (
        .clk(clk), .reset(reset), .raw(raw_a), .clr_cnt(clr_cnt), .occ(a), .cnt(cnt_a)
    );
    tsc_channel #(.DEB_CYCLES(DEB_CYCLES), .GAP_CYCLES(GAP_CYCLES), .CNT_W(CNT_W)) u_b (
        .clk(clk), .reset(reset), .raw(raw_b), .clr_cnt(clr_cnt), .occ(b), .cnt(cnt_b)
    );
endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// tb_traffic_sensor_conditioner: directed vector bench for the sensor conditioner.
module tb_traffic_sensor_conditioner;
    logic       clk = 1'b0, reset = 1'b0, raw_a = 1'b0, raw_b = 1'b0, clr_cnt = 1'b0;
    logic       a, b;
    logic [7:0] cnt_a, cnt_b;
    int         errors = 0, checks = 0;
    typedef struct {
        int         n;
        logic       rst, ra, rb, clr, ea, eb;
        logic [7:0] eca, ecb;
    } vec_t;
    vec_t tv[27];
    traffic_sensor_conditioner #(.DEB_CYCLES(4), .GAP_CYCLES(8), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .raw_a(raw_a), .raw_b(raw_b), .clr_cnt(clr_cnt),
        .a(a), .b(b), .cnt_a(cnt_a), .cnt_b(cnt_b)
    );
    always #5 clk = ~clk;
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    initial begin
        tv[0]  = '{2,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
        tv[1]  = '{5,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
        tv[2]  = '{1,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 8'd1};
        tv[3]  = '{1,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd1, 8'd1};
        tv[4]  = '{1,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd0, 8'd0};
        tv[5]  = '{12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0, 8'd0};
        tv[6]  = '{1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0, 8'd0};
        tv[7]  = '{1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
        tv[8]  = '{3,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
        tv[9]  = '{10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
        tv[10] = '{4,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
        tv[11] = '{1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
        tv[12] = '{1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 8'd0};
        tv[13] = '{1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1, 8'd0};
        tv[14] = '{11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1, 8'd0};
        tv[15] = '{1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 8'd0};
        tv[16] = '{5,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 8'd0};
        tv[17] = '{1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2, 8'd0};
        tv[18] = '{1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2, 8'd0};
        tv[19] = '{13, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2, 8'd0};
        tv[20] = '{5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2, 8'd0};
        tv[21] = '{5,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2, 8'd0};
        tv[22] = '{1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd3, 8'd0};
        tv[23] = '{4,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd3, 8'd0};
        tv[24] = '{13, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd3, 8'd0};
        tv[25] = '{1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd3, 8'd0};
        tv[26] = '{1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3, 8'd0};
        for (int i = 0; i < 27; i++) begin
            reset   = tv[i].rst;
            raw_a   = tv[i].ra;
            raw_b   = tv[i].rb;
            clr_cnt = tv[i].clr;
            step(tv[i].n);
            chk($sformatf("v%0d_a", i), 32'(a), 32'(tv[i].ea));
            chk($sformatf("v%0d_b", i), 32'(b), 32'(tv[i].eb));
            chk($sformatf("v%0d_cnt_a", i), 32'(cnt_a), 32'(tv[i].eca));
            chk($sformatf("v%0d_cnt_b", i), 32'(cnt_b), 32'(tv[i].ecb));
        end
        // B saturation: each 6-high/6-low pulse is one debounced arrival
        for (int i = 0; i < 260; i++) begin
            raw_b = 1'b1;
            step(6);
            raw_b = 1'b0;
            step(6);
            if (i == 0) chk("sat_first", 32'(cnt_b), 32'd1);
            if (i == 254) chk("sat_255", 32'(cnt_b), 32'd255);
        end
        chk("sat_hold", 32'(cnt_b), 32'd255);
        chk("sat_cnt_a", 32'(cnt_a), 32'd3);
        raw_b = 1'b1;
        step(5);
        chk("clr_pre", 32'(cnt_b), 32'd255);
        clr_cnt = 1'b1;
        step(1);
        clr_cnt = 1'b0;
        chk("clr_arrive_b", 32'(cnt_b), 32'd1);
        chk("clr_arrive_a", 32'(cnt_a), 32'd0);
        raw_b = 1'b0;
        raw_a = 1'b1;
        step(8);
        chk("gap_pre_a", 32'(a), 32'd1);
        chk("gap_pre_cnt", 32'(cnt_a), 32'd1);
        raw_a = 1'b0;
        step(8);
        chk("in_gap_a", 32'(a), 32'd1);
        raw_a = 1'b1;
        reset = 1'b0;
        step(1);
        chk("rst_gap_a", 32'(a), 32'd0);
        chk("rst_gap_b", 32'(b), 32'd0);
        chk("rst_gap_cnt_a", 32'(cnt_a), 32'd0);
        chk("rst_gap_cnt_b", 32'(cnt_b), 32'd0);
        reset = 1'b1;
        step(6);
        chk("rel_a_low", 32'(a), 32'd0);
        chk("rel_cnt_a", 32'(cnt_a), 32'd1);
        step(1);
        chk("rel_a_high", 32'(a), 32'd1);
        clr_cnt = 1'b1;
        step(1);
        clr_cnt = 1'b0;
        chk("clr_alone_a", 32'(cnt_a), 32'd0);
        chk("clr_alone_occ", 32'(a), 32'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
